// File: rtl/regbus_pkg.sv
// Shared types and defaults for the register-bus arbiter.
package regbus_pkg;

  localparam int unsigned STROBE_W_DEFAULT = 2;
  localparam int unsigned CNT_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_XFER,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, remembers the last winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       last_grant
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant = {req1, req0};
    if (req0 && req1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner; reset leaves requester 1 as "last" so 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Arbitrates two requesters onto a strobed 8-bit register bus.
module regbus_arbiter
  import regbus_pkg::*;
#(
  parameter int unsigned STROBE_W = STROBE_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_write,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_rvalid,
  output logic [7:0] req0_rdata,
  input  logic       req1_valid,
  input  logic       req1_write,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] req1_rdata,
  output logic [7:0] addr_export,
  output logic [7:0] wdata_export,
  input  logic [7:0] rdata_export,
  output logic       addr_write_export,
  output logic       swrite_export,
  output logic       sread_export,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_W - 1);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             wr_q, wr_n;
  logic [7:0]       addr_n, wdata_n, rdata0_n, rdata1_n;
  logic [1:0]       ready_n, rvalid_n;
  logic             aw_n, sw_n, sr_n, busy_n;
  logic             decide;
  logic [1:0]       grant;
  logic             last_grant;

  // last_grant doubles as the owner of the current transaction: it only
  // advances on an arbitration decision, which never happens mid-transfer.
  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0_valid),
    .req1       (req1_valid),
    .advance    (decide),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Next-state and next-output logic; every output is registered from state_n.
  // Arbitration runs one cycle ahead (in IDLE or DONE) so the ready pulse is
  // a register yet still lands in the first IDLE cycle after DONE.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    wr_n     = wr_q;
    addr_n   = addr_export;
    wdata_n  = wdata_export;
    rdata0_n = req0_rdata;
    rdata1_n = req1_rdata;
    decide   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ({req1_ready, req0_ready} != 2'b00) begin
          state_n = ST_ADDR;
          cnt_n   = CNT_LOAD;
          wr_n    = last_grant ? req1_write : req0_write;
          addr_n  = last_grant ? req1_addr  : req0_addr;
          if (wr_n) begin
            wdata_n = last_grant ? req1_wdata : req0_wdata;
          end
        end else begin
          decide = 1'b1;
        end
      end
      ST_ADDR: begin
        if (cnt_q == '0) begin
          state_n = ST_GAP;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        state_n = ST_XFER;
        cnt_n   = CNT_LOAD;
      end
      ST_XFER: begin
        if (cnt_q == '0) begin
          state_n = ST_DONE;
          if (!wr_q) begin
            if (last_grant) begin
              rdata1_n = rdata_export;
            end else begin
              rdata0_n = rdata_export;
            end
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        decide  = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    ready_n  = decide ? grant : '0;
    aw_n     = (state_n == ST_ADDR);
    sw_n     = (state_n == ST_XFER) && wr_n;
    sr_n     = (state_n == ST_XFER) && !wr_n;
    busy_n   = (state_n != ST_IDLE);
    rvalid_n = '0;
    if ((state_n == ST_DONE) && !wr_n) begin
      rvalid_n = last_grant ? 2'b10 : 2'b01;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      wr_q              <= 1'b0;
      addr_export       <= '0;
      wdata_export      <= '0;
      req0_rdata        <= '0;
      req1_rdata        <= '0;
      req0_ready        <= 1'b0;
      req1_ready        <= 1'b0;
      req0_rvalid       <= 1'b0;
      req1_rvalid       <= 1'b0;
      addr_write_export <= 1'b0;
      swrite_export     <= 1'b0;
      sread_export      <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state_q           <= state_n;
      cnt_q             <= cnt_n;
      wr_q              <= wr_n;
      addr_export       <= addr_n;
      wdata_export      <= wdata_n;
      req0_rdata        <= rdata0_n;
      req1_rdata        <= rdata1_n;
      req0_ready        <= ready_n[0];
      req1_ready        <= ready_n[1];
      req0_rvalid       <= rvalid_n[0];
      req1_rvalid       <= rvalid_n[1];
      addr_write_export <= aw_n;
      swrite_export     <= sw_n;
      sread_export      <= sr_n;
      busy              <= busy_n;
    end
  end

endmodule
